// File: rtl/retire_ctrl.sv
// Retire controller: scans the ROB head each cycle, retires the in-order prefix of
// finished entries, and sequences flush/recovery after a mispredict and a sticky halt.
module retire_ctrl #(
    parameter int N              = 3,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N-1:0]               head_valid,
    input  logic [N-1:0]               head_complete,
    input  logic [N-1:0]               head_mispred,
    input  logic [N-1:0]               head_is_store,
    input  logic [N-1:0]               head_halt,
    input  logic                       sq_ready,
    output logic [$clog2(N+1)-1:0]     num_retiring,
    output logic                       store_commit,
    output logic                       flush,
    output logic                       dispatch_stall,
    output logic                       halted,
    output logic [31:0]                retired_total
);

    localparam int CW = $clog2(N+1);

    localparam logic [1:0] S_NORMAL  = 2'd0;
    localparam logic [1:0] S_FLUSH   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [3:0]    r_recover_cnt;
    logic [3:0]    w_next_recover_cnt;
    logic [31:0]   r_retired_total;
    logic          r_flush;
    logic          r_dispatch_stall;
    logic          r_halted;

    logic [CW-1:0] w_count;
    logic          w_store;
    logic          w_mispred;
    logic          w_halt;
    logic          w_stop;

    // Oldest-first scan; the first entry that cannot retire ends the scan.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_count   = '0;
        w_store   = 1'b0;
        w_mispred = 1'b0;
        w_halt    = 1'b0;
        w_stop    = (r_state != S_NORMAL);
        for (int i = 0; i < N; i++) begin
            if (!w_stop) begin
                if (!(head_valid[i] && head_complete[i])) begin
                    w_stop = 1'b1;
                end else if (head_halt[i]) begin
                    w_count = w_count + 1'b1;
                    w_halt  = 1'b1;
                    w_stop  = 1'b1;
                end else if (head_mispred[i]) begin
                    w_count   = w_count + 1'b1;
                    w_mispred = 1'b1;
                    w_stop    = 1'b1;
                end else if (head_is_store[i] && (!sq_ready || w_store)) begin
                    w_stop = 1'b1;
                end else begin
                    w_count = w_count + 1'b1;
                    if (head_is_store[i]) w_store = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state       = r_state;
        w_next_recover_cnt = r_recover_cnt;
        case (r_state)
            S_NORMAL: begin
                if (w_halt)         w_next_state = S_HALTED;
                else if (w_mispred) w_next_state = S_FLUSH;
            end
            S_FLUSH: begin
                w_next_state       = S_RECOVER;
                w_next_recover_cnt = RECOVER_LOAD;
            end
            S_RECOVER: begin
                if (r_recover_cnt <= 4'd1) begin
                    w_next_state       = S_NORMAL;
                    w_next_recover_cnt = 4'd0;
                end else begin
                    w_next_recover_cnt = r_recover_cnt - 4'd1;
                end
            end
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_NORMAL;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state          <= S_NORMAL;
            r_recover_cnt    <= 4'd0;
            r_retired_total  <= 32'd0;
            r_flush          <= 1'b0;
            r_dispatch_stall <= 1'b0;
            r_halted         <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_recover_cnt    <= w_next_recover_cnt;
            r_retired_total  <= r_retired_total + 32'(w_count);
            r_flush          <= (w_next_state == S_FLUSH);
            r_dispatch_stall <= (w_next_state != S_NORMAL);
            r_halted         <= (w_next_state == S_HALTED);
        end
    end

    assign num_retiring   = w_count;
    assign store_commit   = w_store;
    assign flush          = r_flush;
    assign dispatch_stall = r_dispatch_stall;
    assign halted         = r_halted;
    assign retired_total  = r_retired_total;

endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench for retire_ctrl: a behavioural model pushes expected outputs as
// each cycle is driven; they are popped and compared on the following negedge.
module tb_retire_ctrl;

    localparam int N  = 3;
    localparam int RC = 2;
    localparam int CW = $clog2(N+1);

    localparam int M_NORMAL  = 0;
    localparam int M_FLUSH   = 1;
    localparam int M_RECOVER = 2;
    localparam int M_HALTED  = 3;

    logic          clock;
    logic          reset;
    logic [N-1:0]  head_valid, head_complete, head_mispred, head_is_store, head_halt;
    logic          sq_ready;
    logic [CW-1:0] num_retiring;
    logic          store_commit, flush, dispatch_stall, halted;
    logic [31:0]   retired_total;

    typedef struct {
        logic [CW-1:0] num;
        logic          store;
        logic          flush;
        logic          stall;
        logic          halted;
        logic [31:0]   total;
    } exp_t;

    exp_t        sb[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          m_state      = M_NORMAL;
    int          m_cnt        = 0;
    logic [31:0] m_total      = 32'd0;

    retire_ctrl #(.N(N), .RECOVER_CYCLES(RC)) dut (
        .clock          (clock),
        .reset          (reset),
        .head_valid     (head_valid),
        .head_complete  (head_complete),
        .head_mispred   (head_mispred),
        .head_is_store  (head_is_store),
        .head_halt      (head_halt),
        .sq_ready       (sq_ready),
        .num_retiring   (num_retiring),
        .store_commit   (store_commit),
        .flush          (flush),
        .dispatch_stall (dispatch_stall),
        .halted         (halted),
        .retired_total  (retired_total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural retire rule: stop at the first entry that cannot go.
    task automatic model_scan(input logic [N-1:0] v, c, m, s, h, input logic sq,
                              output int cnt, output logic st, output logic mis, output logic hlt);
        cnt = 0; st = 1'b0; mis = 1'b0; hlt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!v[i] || !c[i]) break;
            if (h[i]) begin cnt++; hlt = 1'b1; break; end
            if (m[i]) begin cnt++; mis = 1'b1; break; end
            if (s[i]) begin
                if (!sq || st) break;
                st = 1'b1;
            end
            cnt++;
        end
    endtask

    // Called at posedge+1: drive, push expectation, advance model, compare at negedge.
    task automatic step(input logic [N-1:0] v, c, m, s, h, input logic sq, input logic rst);
        exp_t e;
        exp_t got;
        int   cnt;
        logic st, mis, hlt;
        head_valid = v; head_complete = c; head_mispred = m;
        head_is_store = s; head_halt = h; sq_ready = sq; reset = rst;
        model_scan(v, c, m, s, h, sq, cnt, st, mis, hlt);
        if (m_state != M_NORMAL) begin
            cnt = 0; st = 1'b0; mis = 1'b0; hlt = 1'b0;
        end
        e.num    = CW'(cnt);
        e.store  = st;
        e.flush  = (m_state == M_FLUSH);
        e.stall  = (m_state != M_NORMAL);
        e.halted = (m_state == M_HALTED);
        e.total  = m_total;
        sb.push_back(e);
        if (rst) begin
            m_state = M_NORMAL; m_cnt = 0; m_total = 32'd0;
        end else begin
            m_total = m_total + 32'(cnt);
            case (m_state)
                M_NORMAL:  if (hlt) m_state = M_HALTED; else if (mis) m_state = M_FLUSH;
                M_FLUSH:   begin m_state = M_RECOVER; m_cnt = RC; end
                M_RECOVER: if (m_cnt == 1) m_state = M_NORMAL; else m_cnt--;
                default:   m_state = M_HALTED;
            endcase
        end
        @(negedge clock);
        got = sb.pop_front();
        check("num_retiring",   32'(num_retiring),  32'(got.num));
        check("store_commit",   32'(store_commit),  32'(got.store));
        check("flush",          32'(flush),         32'(got.flush));
        check("dispatch_stall", 32'(dispatch_stall), 32'(got.stall));
        check("halted",         32'(halted),        32'(got.halted));
        check("retired_total",  retired_total,      got.total);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sq_ready = 1'b0;
        head_valid = '0; head_complete = '0; head_mispred = '0; head_is_store = '0; head_halt = '0;
        repeat (2) @(posedge clock);
        #1;
        // Reset state, then full-width retire
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (3) step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Stores: one per cycle, blocked without sq_ready
        step(3'b111, 3'b111, 3'b000, 3'b101, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b111, 3'b000, 3'b101, 3'b000, 1'b0, 1'b0);
        step(3'b111, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b0);
        // Non-contiguous valid, incomplete oldest
        step(3'b101, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b110, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Mispredict in entry 1: flush, recover, back to normal
        step(3'b111, 3'b111, 3'b010, 3'b000, 3'b000, 1'b1, 1'b0);
        repeat (4) step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Mispredict overrides store flag even with sq_ready low
        step(3'b111, 3'b111, 3'b001, 3'b001, 3'b000, 1'b0, 1'b0);
        step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Reset while in RECOVER
        step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Store then halt retire together
        step(3'b111, 3'b111, 3'b000, 3'b001, 3'b010, 1'b1, 1'b0);
        repeat (2) step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        // Halt on entry 0 beats mispredict on the same entry
        step(3'b111, 3'b111, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
        repeat (2) step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        // Counter wrap from near 2^32-1
        force dut.r_retired_total = 32'hFFFF_FFFE;
        #1;
        release dut.r_retired_total;
        m_total = 32'hFFFF_FFFE;
        repeat (3) step(3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        // Random traffic, rare halts and resets
        for (int k = 0; k < 60; k++) begin
            logic [N-1:0] rh;
            rh = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            step(N'($urandom | $urandom), N'($urandom | $urandom), N'($urandom & $urandom),
                 N'($urandom), rh, 1'($urandom), ($urandom_range(0, 19) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/retire_ctrl.md
RETIRE_CTRL -- requirements
Module: retire_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, retire width (ROB head entries examined per cycle).
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2, dispatch-stall cycles following a flush (legal range 1..15).
REQ-003 SHALL have port clock  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port head_valid  input  N  ROB head entry i holds an instruction; index 0 is oldest.
REQ-006 SHALL have port head_complete  input  N  entry i has finished execution.
REQ-007 SHALL have port head_mispred  input  N  entry i is a resolved mispredicted branch.
REQ-008 SHALL have port head_is_store  input  N  entry i is a store needing a store-queue commit.
REQ-009 SHALL have port head_halt  input  N  entry i is a halt instruction.
REQ-010 SHALL have port sq_ready  input  1  store queue accepts one store commit this cycle.
REQ-011 SHALL have port num_retiring  output  clog2(N+1)  entries the ROB frees this cycle.
REQ-012 SHALL have port store_commit  output  1  one store commits this cycle.
REQ-013 SHALL have port flush  output  1  one-cycle pipeline/ROB squash pulse.
REQ-014 SHALL have port dispatch_stall  output  1  dispatch blocked.
REQ-015 SHALL have port halted  output  1  sticky halt indication.
REQ-016 SHALL have port retired_total  output  32  running count of retired instructions.

Function
REQ-017 SHALL implement FSM states NORMAL, FLUSH, RECOVER, HALTED; only NORMAL retires.
REQ-018 In NORMAL, entry i SHALL retire iff entries 0..i-1 retire and entry i is valid and complete and not blocked; num_retiring is the count, combinational from current inputs.
REQ-019 A store entry SHALL be blocked when sq_ready=0 or an earlier entry in the same cycle already retired a store (max one store per cycle); store_commit=1 iff a store retires.
REQ-020 Per-entry priority SHALL be halt > mispred > store; head_is_store ignored when head_mispred or head_halt set.
REQ-021 A retiring mispredicted entry SHALL retire itself, end the scan (no younger entry retires), and move FSM to FLUSH next cycle.
REQ-022 A retiring halt entry SHALL retire itself, end the scan, and move FSM to HALTED next cycle.
REQ-023 In FLUSH: flush=1, dispatch_stall=1, num_retiring=0, store_commit=0 for exactly one cycle, then RECOVER with counter loaded to RECOVER_CYCLES.
REQ-024 In RECOVER: dispatch_stall=1, retire outputs 0, counter decrements each cycle; return to NORMAL in the cycle after counter reaches 1 (RECOVER lasts exactly RECOVER_CYCLES cycles).
REQ-025 In HALTED: halted=1, dispatch_stall=1, all retire outputs 0; state held until reset.
REQ-026 retired_total SHALL add num_retiring on each clock edge, wrapping modulo 2^32.
REQ-027 Head inputs while not in NORMAL SHALL be ignored; flush, dispatch_stall, halted SHALL be registered (FSM-decoded), not combinational from inputs.
REQ-028 Invalid entries below a valid one (non-contiguous head_valid) SHALL stop the scan at the first invalid entry.

Reset
REQ-029 On reset: state NORMAL, recover counter 0, retired_total 0, flush 0, dispatch_stall 0, halted 0; num_retiring and store_commit follow REQ-018/019 from the next cycle.
REQ-030 Reset asserted in FLUSH, RECOVER or HALTED SHALL abort immediately to NORMAL with no residual flush pulse.

Verification
REQ-031 N=3, all valid+complete, no specials -> num_retiring=3, retired_total +3 per cycle.
REQ-032 Entries 0,2 stores, sq_ready=1 -> num_retiring=2, store_commit=1; sq_ready=0 -> num_retiring=0.
REQ-033 Entry 1 mispred, all complete -> num_retiring=2; next cycle flush=1; then dispatch_stall=1 for 2 cycles; then NORMAL.
REQ-034 Entry 0 halt -> num_retiring=1; halted=1 from next cycle, num_retiring=0 thereafter until reset.
REQ-035 Entry 0 incomplete, entries 1-2 complete -> num_retiring=0; reset during RECOVER -> dispatch_stall=0 next cycle, retired_total=0.
REQ-036 retired_total preset near 2^32-1 via long run, retire 3 -> wraps to low value modulo 2^32.
